// File: rtl/hack_rom_loader.sv
// Serial boot loader: receives a framed program image over UART and writes it into the Hack ROM.
// Optional CHK byte verification is built when ROM_LOADER_CHECKSUM_EN is defined.
module hack_rom_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DEPTH        = 32768,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {UIdle, UStart, UData, UStop} uart_state_e;

    uart_state_e      ust_q, ust_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            ust_q        <= UIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            ust_q        <= ust_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        ust_d        = ust_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (ust_q)
            UIdle: begin
                // Edge-triggered start so a low stop bit cannot immediately re-arm the receiver
                if (rx_prev_q && !rx_sync_q) begin
                    ust_d = UStart;
                    cnt_d = '0;
                end
            end
            UStart: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    bit_d = '0;
                    ust_d = rx_sync_q ? UIdle : UData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UData: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) ust_d = UStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UStop: begin
                if (cnt_q == BIT_END) begin
                    cnt_d        = '0;
                    ust_d        = UIdle;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ust_d = UIdle;
        endcase
    end

    // ---------------- Frame FSM ----------------
    typedef enum logic [2:0] {
        StWaitSync, StLenHi, StLenLo, StDataHi, StDataLo, StRun, StError
`ifdef ROM_LOADER_CHECKSUM_EN
        , StCheck
`endif
    } state_e;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_e StAfterData = StCheck;
`else
    localparam state_e StAfterData = StRun;
`endif

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       rom_wdata_q, rom_wdata_d;
    logic              cpu_reset_q, done_q, err_q;
    logic [7:0]        rx_byte;
    logic [15:0]       len_full;
    logic              sync_hit, last_word;

    assign rx_byte   = shift_q;
    assign len_full  = {len_q[15:8], rx_byte};
    assign sync_hit  = byte_valid_q && (rx_byte == SYNC_BYTE);
    assign last_word = (32'(rom_addr_q) + 32'd1) == 32'(len_q);

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chk_q <= '0;
        else       chk_q <= chk_d;
    end

    always_comb begin
        chk_d = chk_q;
        if (sync_hit && (state_q inside {StWaitSync, StRun, StError})) begin
            chk_d = '0;
        end else if (byte_valid_q && (state_q inside {StLenHi, StLenLo, StDataHi, StDataLo})) begin
            chk_d = chk_q ^ rx_byte;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StWaitSync;
            len_q       <= '0;
            hi_q        <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            // Lag one cycle behind the state so the final ROM write lands before the CPU runs
            cpu_reset_q <= (state_q != StRun);
            done_q      <= (state_q == StRun);
            err_q       <= (state_q == StError);
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        rom_we_d    = 1'b0;
        rom_wdata_d = rom_wdata_q;
        rom_addr_d  = rom_we_q ? rom_addr_q + 1'b1 : rom_addr_q;
        unique case (state_q)
            StWaitSync, StRun, StError: begin
                if (sync_hit) begin
                    state_d    = StLenHi;
                    rom_addr_d = '0;
                end
            end
            StLenHi: begin
                if (frame_err_q) begin
                    state_d = StError;
                end else if (byte_valid_q) begin
                    len_d[15:8] = rx_byte;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (frame_err_q) begin
                    state_d = StError;
                end else if (byte_valid_q) begin
                    len_d = len_full;
                    if (32'(len_full) > DEPTH) state_d = StError;
                    else if (len_full == 16'd0) state_d = StAfterData;
                    else                        state_d = StDataHi;
                end
            end
            StDataHi: begin
                if (frame_err_q) begin
                    state_d = StError;
                end else if (byte_valid_q) begin
                    hi_d    = rx_byte;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (frame_err_q) begin
                    state_d = StError;
                end else if (byte_valid_q) begin
                    rom_we_d    = 1'b1;
                    rom_wdata_d = {hi_q, rx_byte};
                    state_d     = last_word ? StAfterData : StDataHi;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (frame_err_q) begin
                    state_d = StError;
                end else if (byte_valid_q) begin
                    state_d = (rx_byte == chk_q) ? StRun : StError;
                end
            end
`endif
            default: state_d = StWaitSync;
        endcase
    end

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader (CLKS_PER_BIT=16, DEPTH=8); follows ROM_LOADER_CHECKSUM_EN.
module tb_hack_rom_loader;

    localparam int unsigned CPB = 16;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam bit ChkOn = 1'b1;
`else
    localparam bit ChkOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    hack_rom_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (15),
        .DEPTH       (8),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Write log captured mid-cycle
    int          wr_cnt  = 0;
    int          we_run  = 0;
    int          we_max  = 0;
    logic [14:0] wr_addr [0:31];
    logic [15:0] wr_data [0:31];

    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] <= rom_addr;
                wr_data[wr_cnt] <= rom_wdata;
            end
            wr_cnt <= wr_cnt + 1;
            we_run <= we_run + 1;
            if (we_run + 1 > we_max) we_max <= we_run + 1;
        end else begin
            we_run <= 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
        rx = 1'b1;
        idle(2);
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i], 1'b1);
        idle(4);
    endtask

    logic [7:0] fr[$];
    int base;

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        idle(3);
        check("rst_we",        rom_we,    1'b0);
        check("rst_addr",      rom_addr,  15'd0);
        check("rst_wdata",     rom_wdata, 16'h0000);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done",      done,      1'b0);
        check("rst_err",       err,       1'b0);
        reset = 1'b0;
        idle(5);

        // Junk before SYNC, then an empty image
        fr = '{8'h55, 8'hFF, 8'hA5, 8'h00, 8'h00};
        if (ChkOn) fr.push_back(8'h00);
        send_frame(fr);
        check("empty_done",      done,      1'b1);
        check("empty_cpu_reset", cpu_reset, 1'b0);
        check("empty_err",       err,       1'b0);
        check("empty_writes",    wr_cnt,    0);

        // SYNC while running holds the CPU again
        send_byte(8'hA5, 1'b1);
        check("reload_cpu_reset", cpu_reset, 1'b1);
        check("reload_done",      done,      1'b0);

        // Two words; CHK is XOR of LEN and data bytes = 0x42
        fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        if (ChkOn) fr.push_back(8'h42);
        send_frame(fr);
        check("two_writes",    wr_cnt,     2);
        check("w0_addr",       wr_addr[0], 15'd0);
        check("w0_data",       wr_data[0], 16'h1234);
        check("w1_addr",       wr_addr[1], 15'd1);
        check("w1_data",       wr_data[1], 16'hABCD);
        check("two_rom_addr",  rom_addr,   15'd2);
        check("two_done",      done,       1'b1);
        check("two_cpu_reset", cpu_reset,  1'b0);
        check("two_err",       err,        1'b0);

        // Short low glitch on an idle line
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * CPB);
        check("glitch_done",   done,   1'b1);
        check("glitch_err",    err,    1'b0);
        check("glitch_writes", wr_cnt, 2);

`ifdef ROM_LOADER_CHECKSUM_EN
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
        check("badchk_writes",    wr_cnt,     4);
        check("badchk_w3_data",   wr_data[3], 16'hABCD);
        check("badchk_err",       err,        1'b1);
        check("badchk_cpu_reset", cpu_reset,  1'b1);
        check("badchk_done",      done,       1'b0);
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
        check("recover_err",  err,  1'b0);
        check("recover_done", done, 1'b1);
`endif

        // Oversize length: 9 > DEPTH
        base = wr_cnt;
        send_frame('{8'hA5, 8'h00, 8'h09});
        check("big_err",       err,       1'b1);
        check("big_cpu_reset", cpu_reset, 1'b1);
        check("big_done",      done,      1'b0);
        check("big_writes",    wr_cnt,    base);

        // Load from ERROR; CHK = 00^01^BE^EF = 0x50
        fr = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
        if (ChkOn) fr.push_back(8'h50);
        send_frame(fr);
        check("beef_writes", wr_cnt,        base + 1);
        check("beef_addr",   wr_addr[base], 15'd0);
        check("beef_data",   wr_data[base], 16'hBEEF);
        check("beef_done",   done,          1'b1);
        check("beef_err",    err,           1'b0);

        // Framing error on a data byte
        send_frame('{8'hA5, 8'h00, 8'h01});
        send_byte(8'hBE, 1'b0);
        idle(4);
        check("ferr_err",       err,       1'b1);
        check("ferr_done",      done,      1'b0);
        check("ferr_cpu_reset", cpu_reset, 1'b1);

        // Asynchronous reset after the first word of a two-word image
        base = wr_cnt;
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
        check("mid_writes",   wr_cnt,    base + 1);
        check("mid_rom_addr", rom_addr,  15'd1);
        check("mid_wdata",    rom_wdata, 16'h1234);
        check("mid_err",      err,       1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_we",        rom_we,    1'b0);
        check("arst_addr",      rom_addr,  15'd0);
        check("arst_wdata",     rom_wdata, 16'h0000);
        check("arst_cpu_reset", cpu_reset, 1'b1);
        check("arst_done",      done,      1'b0);
        check("arst_err",       err,       1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(5);

        // Remainder of the aborted frame must be ignored until a new SYNC
        send_frame('{8'hAB, 8'hCD});
        check("post_rst_writes", wr_cnt, base + 1);
        check("post_rst_done",   done,   1'b0);
        fr = '{8'hA5, 8'h00, 8'h00};
        if (ChkOn) fr.push_back(8'h00);
        send_frame(fr);
        check("post_rst_run", done, 1'b1);

        check("we_pulse_width", we_max, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
